// File: rtl/mem_wb_if.sv
// mem_wb_if: EX-side inputs, stall/flush controls and writeback/forwarding outputs of the MEM+WB stage
interface mem_wb_if #(parameter int DATA_W = 16, parameter int REG_W = 4);
  logic              ex_valid;
  logic              ex_wbs;
  logic              ex_mem_rd;
  logic              ex_mem_wr;
  logic              ex_reg_we;
  logic [REG_W-1:0]  ex_reg_dest;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              stall;
  logic              flush;
  logic              mem_load_pending;
  logic              wb_valid;
  logic              wb_reg_we;
  logic [REG_W-1:0]  wb_reg_dest;
  logic [DATA_W-1:0] wb_data;
  logic              fwd_mem_valid;
  logic [REG_W-1:0]  fwd_mem_dest;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_wb_valid;
  logic [REG_W-1:0]  fwd_wb_dest;
  logic [DATA_W-1:0] fwd_wb_data;
  modport master (
    output ex_valid, ex_wbs, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_reg_dest, ex_alu_result, ex_store_data,
           stall, flush,
    input  mem_load_pending, wb_valid, wb_reg_we, wb_reg_dest, wb_data,
           fwd_mem_valid, fwd_mem_dest, fwd_mem_data, fwd_wb_valid, fwd_wb_dest, fwd_wb_data
  );
  modport slave (
    input  ex_valid, ex_wbs, ex_mem_rd, ex_mem_wr, ex_reg_we, ex_reg_dest, ex_alu_result, ex_store_data,
           stall, flush,
    output mem_load_pending, wb_valid, wb_reg_we, wb_reg_dest, wb_data,
           fwd_mem_valid, fwd_mem_dest, fwd_mem_data, fwd_wb_valid, fwd_wb_dest, fwd_wb_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM register, synchronous data RAM, MEM/WB register and WB source mux.
// Define MEMWB_FWD_EN to build the MEM/WB forwarding outputs; otherwise they are tied to 0.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 4
) (
  input logic   clk,
  input logic   rst,
  mem_wb_if.slave bus
);
  logic              mem_valid, mem_wbs, mem_rd, mem_wr, mem_reg_we;
  logic [REG_W-1:0]  mem_reg_dest;
  logic [DATA_W-1:0] mem_alu_result, mem_store_data;
  logic              wb_valid_q, wb_wbs, wb_reg_we_q;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_calc, rd_q;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] addr;
  logic              do_wr, do_rd;
  assign addr  = mem_alu_result[ADDR_W-1:0];
  assign do_wr = mem_valid & mem_wr & ~bus.stall;
  assign do_rd = mem_valid & mem_rd & ~mem_wr & ~bus.stall;
  // RAM has no reset so its contents survive rst
  always_ff @(posedge clk)
    if (!rst && do_wr) ram[addr] <= mem_store_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_wbs        <= 1'b0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_reg_we     <= 1'b0;
      mem_reg_dest   <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      rd_q           <= '0;
      wb_valid_q     <= 1'b0;
      wb_wbs         <= 1'b0;
      wb_reg_we_q    <= 1'b0;
      wb_dest        <= '0;
      wb_calc        <= '0;
    end else if (!bus.stall) begin
      mem_valid      <= bus.ex_valid & ~bus.flush;
      mem_wbs        <= bus.ex_wbs;
      mem_rd         <= bus.ex_mem_rd;
      mem_wr         <= bus.ex_mem_wr;
      mem_reg_we     <= bus.ex_reg_we;
      mem_reg_dest   <= bus.ex_reg_dest;
      mem_alu_result <= bus.ex_alu_result;
      mem_store_data <= bus.ex_store_data;
      if (do_rd) rd_q <= ram[addr];
      wb_valid_q     <= mem_valid;
      wb_wbs         <= mem_wbs;
      wb_reg_we_q    <= mem_reg_we;
      wb_dest        <= mem_reg_dest;
      wb_calc        <= mem_alu_result;
    end
  end
  assign bus.mem_load_pending = mem_valid & mem_rd & ~mem_wr;
  assign bus.wb_valid         = wb_valid_q;
  assign bus.wb_reg_we        = wb_valid_q & wb_reg_we_q;
  assign bus.wb_reg_dest      = wb_dest;
  assign bus.wb_data          = wb_wbs ? wb_calc : rd_q;
`ifdef MEMWB_FWD_EN
  // loads are excluded: their data is not ready until WB
  assign bus.fwd_mem_valid = mem_valid & mem_reg_we & ~mem_rd;
  assign bus.fwd_mem_dest  = mem_reg_dest;
  assign bus.fwd_mem_data  = mem_alu_result;
  assign bus.fwd_wb_valid  = bus.wb_reg_we;
  assign bus.fwd_wb_dest   = bus.wb_reg_dest;
  assign bus.fwd_wb_data   = bus.wb_data;
`else
  assign bus.fwd_mem_valid = 1'b0;
  assign bus.fwd_mem_dest  = '0;
  assign bus.fwd_mem_data  = '0;
  assign bus.fwd_wb_valid  = 1'b0;
  assign bus.fwd_wb_dest   = '0;
  assign bus.fwd_wb_data   = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed stimulus with a transaction-level pipeline/RAM model checked every cycle
module tb_mem_wb_stage;
  typedef struct {
    logic        v, wbs, rd, wr, we;
    logic [3:0]  dest;
    logic [15:0] alu, sd;
  } ins_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  mem_wb_if #(.DATA_W(16), .REG_W(4)) bus ();
  mem_wb_stage #(.DATA_W(16), .ADDR_W(8), .REG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  ins_t        m_slot, w_slot;
  logic [15:0] ram [256];
  bit          known [256];
  logic [15:0] lat;
  bit          lat_k = 0;
  bit          armed = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  function automatic ins_t mk(input logic v, wbs, rd, wr, we, input logic [3:0] dest,
                              input logic [15:0] alu, sd);
    ins_t i;
    i.v = v; i.wbs = wbs; i.rd = rd; i.wr = wr; i.we = we; i.dest = dest; i.alu = alu; i.sd = sd;
    return i;
  endfunction
  // model: one instruction per slot, memory as an array with known flags
  always @(posedge clk) begin
    automatic ins_t e = mk(bus.ex_valid & ~bus.flush, bus.ex_wbs, bus.ex_mem_rd, bus.ex_mem_wr,
                           bus.ex_reg_we, bus.ex_reg_dest, bus.ex_alu_result, bus.ex_store_data);
    armed = 1;
    if (rst) begin
      m_slot = mk(0, 0, 0, 0, 0, 0, 0, 0);
      w_slot = m_slot;
      lat = 0;
      lat_k = 1;
    end else if (!bus.stall) begin
      if (m_slot.v && m_slot.wr) begin
        ram[m_slot.alu[7:0]] = m_slot.sd;
        known[m_slot.alu[7:0]] = 1;
      end else if (m_slot.v && m_slot.rd) begin
        lat = ram[m_slot.alu[7:0]];
        lat_k = known[m_slot.alu[7:0]];
      end
      w_slot = m_slot;
      m_slot = e;
    end
  end
  always @(negedge clk) if (armed) begin
    automatic logic we_exp = w_slot.v & w_slot.we;
    automatic logic [15:0] d_exp = w_slot.wbs ? w_slot.alu : lat;
    chk("wb_valid", bus.wb_valid, w_slot.v);
    chk("wb_reg_we", bus.wb_reg_we, we_exp);
    chk("mem_load_pending", bus.mem_load_pending, m_slot.v & m_slot.rd & ~m_slot.wr);
    if (w_slot.v) chk("wb_reg_dest", bus.wb_reg_dest, w_slot.dest);
    if (w_slot.v && (w_slot.wbs || lat_k)) chk("wb_data", bus.wb_data, d_exp);
`ifdef MEMWB_FWD_EN
    chk("fwd_mem_valid", bus.fwd_mem_valid, m_slot.v & m_slot.we & ~m_slot.rd);
    if (m_slot.v & m_slot.we & ~m_slot.rd) begin
      chk("fwd_mem_dest", bus.fwd_mem_dest, m_slot.dest);
      chk("fwd_mem_data", bus.fwd_mem_data, m_slot.alu);
    end
    chk("fwd_wb_valid", bus.fwd_wb_valid, we_exp);
    if (we_exp) chk("fwd_wb_dest", bus.fwd_wb_dest, w_slot.dest);
    if (we_exp && (w_slot.wbs || lat_k)) chk("fwd_wb_data", bus.fwd_wb_data, d_exp);
`else
    chk("fwd_all_zero", {bus.fwd_mem_valid, bus.fwd_mem_dest, bus.fwd_mem_data, bus.fwd_wb_valid,
                         bus.fwd_wb_dest, bus.fwd_wb_data}, 0);
`endif
  end
  task automatic step(input ins_t i, input logic st, input logic fl, input logic r);
    bus.ex_valid = i.v; bus.ex_wbs = i.wbs; bus.ex_mem_rd = i.rd; bus.ex_mem_wr = i.wr;
    bus.ex_reg_we = i.we; bus.ex_reg_dest = i.dest; bus.ex_alu_result = i.alu; bus.ex_store_data = i.sd;
    bus.stall = st; bus.flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask
  function automatic ins_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic ins_t alu_op(input logic [15:0] a, input logic [3:0] d);
    return mk(1, 1, 0, 0, 1, d, a, 0);
  endfunction
  function automatic ins_t store(input logic [15:0] a, input logic [15:0] d);
    return mk(1, 1, 0, 1, 0, 0, a, d);
  endfunction
  function automatic ins_t load(input logic [15:0] a, input logic [3:0] d);
    return mk(1, 0, 1, 0, 1, d, a, 0);
  endfunction
  initial begin
    step(idle(), 0, 0, 1);
    step(store(16'h0005, 16'h1111), 0, 0, 0);
    step(idle(), 0, 0, 0);
    step(store(16'h0005, 16'hBEEF), 0, 0, 1);
    step(store(16'h0005, 16'hBEEF), 0, 0, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_pending", bus.mem_load_pending, 0);
    step(load(16'h0005, 4'd1), 0, 0, 0);
    chk("load_pending", bus.mem_load_pending, 1);
    step(idle(), 0, 0, 0);
    chk("rst_no_store", bus.wb_data, 16'h1111);
    step(alu_op(16'h1234, 4'd2), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("alu_we", bus.wb_reg_we, 1);
    chk("alu_dest", bus.wb_reg_dest, 2);
    chk("alu_data", bus.wb_data, 16'h1234);
    step(store(16'h0003, 16'h00A5), 0, 0, 0);
    step(load(16'h0003, 4'd4), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("st_ld_data", bus.wb_data, 16'h00A5);
    chk("st_ld_dest", bus.wb_reg_dest, 4);
    step(alu_op(16'h7777, 4'd6), 0, 0, 0);
    step(load(16'h0003, 4'd5), 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(alu_op(16'h9999, 4'd9), 1, k == 1, 0);
      chk("stall_wb_data", bus.wb_data, 16'h7777);
      chk("stall_wb_dest", bus.wb_reg_dest, 6);
      chk("stall_pending", bus.mem_load_pending, 1);
    end
    step(idle(), 0, 0, 0);
    chk("release_data", bus.wb_data, 16'h00A5);
    chk("release_dest", bus.wb_reg_dest, 5);
    step(store(16'h0005, 16'hFFFF), 0, 1, 0);
    step(idle(), 0, 0, 0);
    chk("flush_wb_valid", bus.wb_valid, 0);
    step(load(16'h0005, 4'd3), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("flush_ram_kept", bus.wb_data, 16'h1111);
    step(store(16'h0103, 16'h5A5A), 0, 0, 0);
    step(load(16'h0003, 4'd8), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("wrap_data", bus.wb_data, 16'h5A5A);
    step(mk(1, 0, 1, 1, 1, 4'd10, 16'h0010, 16'h0C0C), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("rdwr_no_latch", bus.wb_data, 16'h5A5A);
    step(load(16'h0010, 4'd11), 0, 0, 0);
    step(idle(), 0, 0, 0);
    chk("rdwr_stored", bus.wb_data, 16'h0C0C);
    step(alu_op(16'h0042, 4'd7), 0, 0, 0);
`ifdef MEMWB_FWD_EN
    chk("fwd_mem_valid_lit", bus.fwd_mem_valid, 1);
    chk("fwd_mem_data_lit", bus.fwd_mem_data, 16'h0042);
`else
    chk("fwd_mem_valid_off", bus.fwd_mem_valid, 0);
    chk("fwd_mem_data_off", bus.fwd_mem_data, 0);
`endif
    step(idle(), 0, 0, 0);
`ifdef MEMWB_FWD_EN
    chk("fwd_wb_valid_lit", bus.fwd_wb_valid, 1);
`else
    chk("fwd_wb_valid_off", bus.fwd_wb_valid, 0);
`endif
    step(idle(), 0, 0, 0);
    step(idle(), 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
